// File: rtl/pixel_blitter.sv
`default_nettype none
// ============================================================================
// pixel_blitter: fill / sprite blit engine emitting a clipped VGA pixel stream
// Revision: 1.0
// ============================================================================
module pixel_blitter #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int XW       = 9,
    parameter int YW       = 8,
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int ADDR_W   = 8,
    parameter int COLOUR_W = 15,
    parameter int ROM_LAT  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [XW-1:0]       originX,
    input  logic [YW-1:0]       originY,
    input  logic [COLOUR_W-1:0] fill_colour,
    input  logic [COLOUR_W-1:0] key_colour,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic                busy,
    output logic                done,
    output logic [XW-1:0]       X,
    output logic [YW-1:0]       Y,
    output logic [COLOUR_W-1:0] Colour,
    output logic                writeEn
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int              C_SW_LOG      = $clog2(SPR_W);
    localparam logic [XW:0]     C_SCR_W       = (XW+1)'(SCREEN_W);
    localparam logic [YW:0]     C_SCR_H       = (YW+1)'(SCREEN_H);
    localparam logic [XW-1:0]   C_FILL_LAST_I = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0]   C_FILL_LAST_J = YW'(SCREEN_H - 1);
    localparam logic [XW-1:0]   C_SPR_LAST_I  = XW'(SPR_W - 1);
    localparam logic [YW-1:0]   C_SPR_LAST_J  = YW'(SPR_H - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;

    logic [1:0]            r_mode;
    logic [XW-1:0]         r_org_x;
    logic [YW-1:0]         r_org_y;
    logic [COLOUR_W-1:0]   r_fill;
    logic [COLOUR_W-1:0]   r_key;

    logic [XW-1:0]         r_i;
    logic [YW-1:0]         r_j;
    logic                  w_last_i;
    logic                  w_last_j;
    logic                  w_last_pix;

    logic [XW:0]           w_sum_x;
    logic [YW:0]           w_sum_y;
    logic [XW:0]           r_px [1:ROM_LAT];
    logic [YW:0]           r_py [1:ROM_LAT];
    logic [ROM_LAT:1]      r_pv;

    logic                  w_in_bounds;
    logic                  w_key_hit;
    logic                  w_write;
    logic [COLOUR_W-1:0]   w_colour;

    logic                  r_busy;
    logic                  r_done;
    logic [XW-1:0]         r_x;
    logic [YW-1:0]         r_y;
    logic [COLOUR_W-1:0]   r_colour;
    logic                  r_we;

    assign w_last_i   = (r_i == ((r_mode == 2'd0) ? C_FILL_LAST_I : C_SPR_LAST_I));
    assign w_last_j   = (r_j == ((r_mode == 2'd0) ? C_FILL_LAST_J : C_SPR_LAST_J));
    assign w_last_pix = w_last_i && w_last_j;

    // Sums keep one extra bit so an off-screen pixel is never mistaken for a wrapped one.
    assign w_sum_x = {1'b0, r_org_x} + {1'b0, r_i};
    assign w_sum_y = {1'b0, r_org_y} + {1'b0, r_j};

    // SPR_W is a power of two, so j*SPR_W is a shift; mode 0 simply truncates.
    assign rom_addr = ADDR_W'(r_i) + ADDR_W'({r_j, {C_SW_LOG{1'b0}}});

    assign w_in_bounds = (r_px[ROM_LAT] < C_SCR_W) && (r_py[ROM_LAT] < C_SCR_H);
    assign w_key_hit   = r_mode[1] && (rom_data == r_key);
    assign w_write     = w_in_bounds && !w_key_hit;
    assign w_colour    = ((r_mode == 2'd0) || (r_mode == 2'd3)) ? r_fill : rom_data;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_last_pix) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!(|r_pv)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SCAN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mode   <= 2'd0;
            r_org_x  <= '0;
            r_org_y  <= '0;
            r_fill   <= '0;
            r_key    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_pv     <= '0;
            for (int s = 1; s <= ROM_LAT; s++) begin
                r_px[s] <= '0;
                r_py[s] <= '0;
            end
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_we     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_SCAN) || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);

            if (w_accept) begin
                r_mode  <= mode;
                r_org_x <= (mode == 2'd0) ? '0 : originX;
                r_org_y <= (mode == 2'd0) ? '0 : originY;
                r_fill  <= fill_colour;
                r_key   <= key_colour;
                r_i     <= '0;
                r_j     <= '0;
            end else if ((r_state == S_SCAN) && !w_last_pix) begin
                if (w_last_i) begin
                    r_i <= '0;
                    r_j <= r_j + 1'b1;
                end else begin
                    r_i <= r_i + 1'b1;
                end
            end

            // Coordinates travel ROM_LAT stages so they meet the matching rom_data.
            r_pv[1] <= (r_state == S_SCAN);
            r_px[1] <= w_sum_x;
            r_py[1] <= w_sum_y;
            for (int s = 2; s <= ROM_LAT; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_px[s] <= r_px[s-1];
                r_py[s] <= r_py[s-1];
            end

            if (r_pv[ROM_LAT]) begin
                r_x      <= r_px[ROM_LAT][XW-1:0];
                r_y      <= r_py[ROM_LAT][YW-1:0];
                r_colour <= w_colour;
                r_we     <= w_write;
            end else begin
                r_we     <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign X       = r_x;
    assign Y       = r_y;
    assign Colour  = r_colour;
    assign writeEn = r_we;

endmodule
`default_nettype wire

// File: tb/tb_pixel_blitter.sv
`default_nettype none
// tb_pixel_blitter: directed checks on two blitters (ROM latency 1 and 2) driven in lockstep.
module tb_pixel_blitter;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int AW = 8;
    localparam int CW = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [XW-1:0] originX = '0;
    logic [YW-1:0] originY = '0;
    logic [CW-1:0] fill_colour = '0;
    logic [CW-1:0] key_colour = '0;

    logic [AW-1:0] rom_addr1, rom_addr2;
    logic [CW-1:0] rom_data1, rom_data2, rom_d2a;
    logic          busy1, done1, we1, busy2, done2, we2;
    logic [XW-1:0] x1, x2;
    logic [YW-1:0] y1, y2;
    logic [CW-1:0] col1, col2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    int rom_kind = 0;
    int op_mode = 0, op_x = 0, op_y = 0;
    logic [CW-1:0] op_fill = '0, op_key = '0;

    int n_wr[2], first_cyc[2], first_x[2], first_y[2], last_x[2], last_y[2];
    int n_done[2], first_done[2], done_cyc[2], done_busy[2], bad[2], spot[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pixel_blitter #(.ROM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .originX(originX), .originY(originY),
        .fill_colour(fill_colour), .key_colour(key_colour),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .busy(busy1), .done(done1), .X(x1), .Y(y1), .Colour(col1), .writeEn(we1)
    );

    pixel_blitter #(.ROM_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .originX(originX), .originY(originY),
        .fill_colour(fill_colour), .key_colour(key_colour),
        .rom_addr(rom_addr2), .rom_data(rom_data2),
        .busy(busy2), .done(done2), .X(x2), .Y(y2), .Colour(col2), .writeEn(we2)
    );

    // kind 0: data = address; kind 1: odd addresses hold their address, even ones hold 0
    function automatic logic [CW-1:0] rom_f(input logic [AW-1:0] a);
        if (rom_kind == 1 && a[0] == 1'b0) return '0;
        return CW'(a);
    endfunction

    always @(posedge clk) begin
        rom_data1 <= rom_f(rom_addr1);
        rom_d2a   <= rom_f(rom_addr2);
        rom_data2 <= rom_d2a;
    end

    task automatic mon(input int d, input logic we, input logic [XW-1:0] x, input logic [YW-1:0] y,
                       input logic [CW-1:0] c, input logic dn, input logic bz);
        int a;
        logic [CW-1:0] e;
        if (we) begin
            if (n_wr[d] == 0) begin
                first_cyc[d] = cyc - t0;
                first_x[d] = int'(x);
                first_y[d] = int'(y);
            end
            n_wr[d]++;
            last_x[d] = int'(x);
            last_y[d] = int'(y);
            if (x == 9'd103 && y == 8'd52) spot[d] = int'(c);
            if (x >= 9'd320 || y >= 8'd240) begin
                bad[d]++;
            end else if (op_mode == 0) begin
                if (c !== op_fill) bad[d]++;
            end else begin
                a = (int'(y) - op_y) * 16 + (int'(x) - op_x);
                if (a < 0 || a > 255 || int'(x) < op_x || int'(x) > op_x + 15) begin
                    bad[d]++;
                end else begin
                    e = rom_f(AW'(a));
                    if (op_mode == 3) begin
                        if (c !== op_fill) bad[d]++;
                    end else if (c !== e) begin
                        bad[d]++;
                    end
                    if (op_mode >= 2 && e == op_key) bad[d]++;
                end
            end
        end
        if (dn) begin
            if (n_done[d] == 0) first_done[d] = cyc - t0;
            n_done[d]++;
            done_cyc[d] = cyc - t0;
            if (bz) done_busy[d]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, we1, x1, y1, col1, done1, busy1);
        mon(1, we2, x2, y2, col2, done2, busy2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            n_wr[d] = 0; first_cyc[d] = -1; first_x[d] = -1; first_y[d] = -1;
            last_x[d] = -1; last_y[d] = -1; n_done[d] = 0; first_done[d] = -1;
            done_cyc[d] = -1; done_busy[d] = 0; bad[d] = 0; spot[d] = -1;
        end
    endtask

    task automatic launch(input logic [1:0] m, input int ox, input int oy,
                          input logic [CW-1:0] f, input logic [CW-1:0] k, input bit hold);
        @(negedge clk);
        mode = m; originX = XW'(ox); originY = YW'(oy);
        fill_colour = f; key_colour = k; start = 1'b1;
        op_mode = int'(m); op_x = (m == 2'd0) ? 0 : ox; op_y = (m == 2'd0) ? 0 : oy;
        op_fill = f; op_key = k;
        t0 = cyc + 1;
        clear_stats();
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k = 0;
        while ((n_done[0] < n || n_done[1] < n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_completed"}, 32'(n_done[0] >= n && n_done[1] >= n), 32'd1);
        repeat (8) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy1"}, 32'(busy1), 0);  chk({tag, "_busy2"}, 32'(busy2), 0);
        chk({tag, "_done1"}, 32'(done1), 0);  chk({tag, "_done2"}, 32'(done2), 0);
        chk({tag, "_we1"}, 32'(we1), 0);      chk({tag, "_we2"}, 32'(we2), 0);
        chk({tag, "_x1"}, 32'(x1), 0);        chk({tag, "_x2"}, 32'(x2), 0);
        chk({tag, "_y1"}, 32'(y1), 0);        chk({tag, "_y2"}, 32'(y2), 0);
        chk({tag, "_col1"}, 32'(col1), 0);    chk({tag, "_col2"}, 32'(col2), 0);
        chk({tag, "_addr1"}, 32'(rom_addr1), 0);
        chk({tag, "_addr2"}, 32'(rom_addr2), 0);
    endtask

    // Sprite ops on both DUTs: write count, done cycle (256+LAT+1), model violations.
    task automatic chk_sprite(input string tag, input int writes);
        chk({tag, "_wr1"}, 32'(n_wr[0]), 32'(writes));
        chk({tag, "_wr2"}, 32'(n_wr[1]), 32'(writes));
        chk({tag, "_done_cyc1"}, 32'(done_cyc[0]), 32'd258);
        chk({tag, "_done_cyc2"}, 32'(done_cyc[1]), 32'd259);
        chk({tag, "_ndone1"}, 32'(n_done[0]), 32'd1);
        chk({tag, "_ndone2"}, 32'(n_done[1]), 32'd1);
        chk({tag, "_bad1"}, 32'(bad[0]), 32'd0);
        chk({tag, "_bad2"}, 32'(bad[1]), 32'd0);
    endtask

    initial begin
        clear_stats();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset mid-fill abandons the operation silently
        rom_kind = 0;
        launch(2'd0, 0, 0, 15'h7FFF, 15'h0000, 1'b0);
        while (cyc - t0 < 50) @(negedge clk);
        chk("t1_busy_mid", 32'(busy1 & busy2), 32'd1);
        chk("t1_first_cyc1", 32'(first_cyc[0]), 32'd2);
        chk("t1_first_cyc2", 32'(first_cyc[1]), 32'd3);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("t1_rst");
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("t1_no_done1", 32'(n_done[0]), 32'd0);
        chk("t1_no_done2", 32'(n_done[1]), 32'd0);
        chk("t1_idle_busy", 32'(busy1 | busy2), 32'd0);

        // Full-screen fill
        launch(2'd0, 0, 0, 15'h7FFF, 15'h0000, 1'b0);
        wait_done(1, 76900, "t2");
        chk("t2_wr1", 32'(n_wr[0]), 32'd76800);
        chk("t2_wr2", 32'(n_wr[1]), 32'd76800);
        chk("t2_first_cyc1", 32'(first_cyc[0]), 32'd2);
        chk("t2_first_cyc2", 32'(first_cyc[1]), 32'd3);
        chk("t2_first_xy1", 32'(first_x[0] * 1000 + first_y[0]), 32'd0);
        chk("t2_last_x1", 32'(last_x[0]), 32'd319);
        chk("t2_last_y1", 32'(last_y[0]), 32'd239);
        chk("t2_last_x2", 32'(last_x[1]), 32'd319);
        chk("t2_last_y2", 32'(last_y[1]), 32'd239);
        chk("t2_done_cyc1", 32'(done_cyc[0]), 32'd76802);
        chk("t2_done_cyc2", 32'(done_cyc[1]), 32'd76803);
        chk("t2_ndone1", 32'(n_done[0]), 32'd1);
        chk("t2_done_busy", 32'(done_busy[0] + done_busy[1]), 32'd0);
        chk("t2_bad1", 32'(bad[0]), 32'd0);
        chk("t2_bad2", 32'(bad[1]), 32'd0);

        // Opaque sprite at (100,50), data = address
        launch(2'd1, 100, 50, 15'h0000, 15'h0000, 1'b0);
        wait_done(1, 400, "t3");
        chk_sprite("t3", 256);
        chk("t3_spot1", 32'(spot[0]), 32'd35);
        chk("t3_spot2", 32'(spot[1]), 32'd35);
        chk("t3_first_xy2", 32'(first_x[1] * 1000 + first_y[1]), 32'd100050);
        chk("t3_first_cyc2", 32'(first_cyc[1]), 32'd3);

        // Colour-keyed and mask-tinted sprites: even addresses are transparent
        rom_kind = 1;
        launch(2'd2, 200, 100, 15'h0000, 15'h0000, 1'b0);
        wait_done(1, 400, "t4k");
        chk_sprite("t4k", 128);
        launch(2'd3, 200, 100, 15'h001F, 15'h0000, 1'b0);
        wait_done(1, 400, "t4t");
        chk_sprite("t4t", 128);
        chk("t4t_last_colour1", 32'(col1), 32'h001F);

        // Sprite straddling the bottom-right corner is clipped
        rom_kind = 0;
        launch(2'd1, 310, 230, 15'h0000, 15'h0000, 1'b0);
        wait_done(1, 400, "t5");
        chk_sprite("t5", 100);
        chk("t5_last_x1", 32'(last_x[0]), 32'd319);
        chk("t5_last_y1", 32'(last_y[0]), 32'd239);

        // start held high: ignored while busy, re-accepted in the DONE cycle
        launch(2'd1, 0, 0, 15'h0000, 15'h0000, 1'b1);
        while (cyc - t0 < 100) @(negedge clk);
        chk("t6_busy_held", 32'(busy1 & busy2), 32'd1);
        chk("t6_no_early_done", 32'(n_done[0] + n_done[1]), 32'd0);
        while (cyc - t0 < 300) @(negedge clk);
        start = 1'b0;
        wait_done(2, 800, "t6");
        chk("t6_ndone1", 32'(n_done[0]), 32'd2);
        chk("t6_ndone2", 32'(n_done[1]), 32'd2);
        chk("t6_first_done1", 32'(first_done[0]), 32'd258);
        chk("t6_first_done2", 32'(first_done[1]), 32'd259);
        chk("t6_second_done1", 32'(done_cyc[0]), 32'd517);
        chk("t6_second_done2", 32'(done_cyc[1]), 32'd519);
        chk("t6_wr1", 32'(n_wr[0]), 32'd512);
        chk("t6_wr2", 32'(n_wr[1]), 32'd512);
        chk("t6_bad", 32'(bad[0] + bad[1]), 32'd0);
        chk("t6_idle", 32'(busy1 | busy2 | we1 | we2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
